mem_stage_lsu: RTL and testbench

- MEM pipeline stage, sits directly upstream of the write-back stage.
- Latches one instruction from EXE and waits for the data-SRAM response when that instruction issued a load/store request.
- Aligns and sign/zero-extends load data, then hands {passthrough, gr_we, dest, final_result} to WB with a valid/allowin handshake.
- Produces a bypass bus for ID hazard detection and discards stale SRAM responses after a WB flush.

---
 rtl/mem_stage_lsu_if.sv | 33 +++
 rtl/mem_stage_lsu.sv | 130 +++++++++++++
 tb/tb_mem_stage_lsu.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_lsu_if.sv
// Handshake and data-bus bundle around the MEM stage: EXE input, WB output,
// data-SRAM response, flush and the ID bypass bus.
interface mem_stage_lsu_if #(
    parameter int PASS_W = 180
);
    localparam int ES_BUS_W = PASS_W + 45;
    localparam int WS_BUS_W = PASS_W + 38;

    logic                es_to_ms_valid;
    logic [ES_BUS_W-1:0] es_to_ms_bus;
    logic                ms_allowin;
    logic                ws_allowin;
    logic                ms_to_ws_valid;
    logic [WS_BUS_W-1:0] ms_to_ws_bus;
    logic                wb_flush;
    logic                data_sram_data_ok;
    logic [31:0]         data_sram_rdata;
    logic [38:0]         ms_fwd_bus;
    logic                ms_ex;

    // master: the MEM stage itself; slave: the surrounding pipeline and SRAM
    modport master (
        input  es_to_ms_valid, es_to_ms_bus, ws_allowin, wb_flush,
               data_sram_data_ok, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus, ms_ex
    );

    modport slave (
        output es_to_ms_valid, es_to_ms_bus, ws_allowin, wb_flush,
               data_sram_data_ok, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus, ms_ex
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: holds one instruction, waits for its data-SRAM response,
// aligns load data and hands the result to WB; drops stale responses after a flush.
module mem_stage_lsu #(
    parameter int PASS_W = 180
) (
    input  logic            clk,
    input  logic            reset,
    mem_stage_lsu_if.master lsu
);
    localparam int ES_BUS_W = PASS_W + 45;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_WORD_ALT = 2'd3
    } ld_size_e;

    typedef struct packed {
        logic [PASS_W-1:0] pass;
        logic              ex;
        logic              mem_req;
        logic              ld_signed;
        ld_size_e          ld_size;
        logic [1:0]        addr_lo;
        logic              gr_we;
        logic [4:0]        dest;
        logic [31:0]       alu_result;
    } es_bus_t;

    es_bus_t     es_in;
    es_bus_t     bus_r;
    logic        ms_valid;
    logic [31:0] data_buf;
    logic        data_buf_valid;
    logic [1:0]  discard_cnt;
    logic [2:0]  discard_sum;

    logic        rsp_taken;
    logic        wait_resp;
    logic        ms_ready_go;
    logic        ms_leave;
    logic        es_in_req;
    logic [31:0] raw;
    logic [15:0] sh;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign es_in     = es_bus_t'(lsu.es_to_ms_bus);
    assign es_in_req = lsu.es_to_ms_valid & es_in.mem_req;

    assign rsp_taken   = lsu.data_sram_data_ok & (discard_cnt == 2'd0);
    assign wait_resp   = ms_valid & bus_r.mem_req & ~bus_r.ex;
    assign ms_ready_go = ~wait_resp | data_buf_valid | rsp_taken;
    assign ms_leave    = ms_valid & ms_ready_go & lsu.ws_allowin;

    assign lsu.ms_allowin     = ~ms_valid | (ms_ready_go & lsu.ws_allowin);
    assign lsu.ms_to_ws_valid = ms_valid & ms_ready_go & ~lsu.wb_flush;
    assign lsu.ms_ex          = ms_valid & (bus_r.ex | lsu.wb_flush);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (lsu.wb_flush) begin
            ms_valid <= 1'b0;
        end else if (lsu.ms_allowin) begin
            ms_valid <= lsu.es_to_ms_valid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_r <= '0;
        end else if (lsu.es_to_ms_valid & lsu.ms_allowin & ~lsu.wb_flush) begin
            bus_r <= es_in;
        end
    end

    // Response arrived but WB is stalled: park the data until the instruction leaves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_buf       <= '0;
            data_buf_valid <= 1'b0;
        end else if (lsu.wb_flush | ms_leave) begin
            data_buf_valid <= 1'b0;
        end else if (rsp_taken & wait_resp & ~data_buf_valid & ~lsu.ws_allowin) begin
            data_buf       <= lsu.data_sram_rdata;
            data_buf_valid <= 1'b1;
        end
    end

    // NOTE: combinational blocks assign a default first so no path can infer a latch.
    always_comb begin
        discard_sum = {1'b0, discard_cnt};
        if (lsu.data_sram_data_ok && discard_cnt != 2'd0) begin
            discard_sum = discard_sum - 3'd1;
        end
        if (lsu.wb_flush & wait_resp & ~data_buf_valid & ~rsp_taken) begin
            discard_sum = discard_sum + 3'd1 + {2'b00, es_in_req};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            discard_cnt <= 2'd0;
        end else begin
            discard_cnt <= (discard_sum > 3'd3) ? 2'd3 : discard_sum[1:0];
        end
    end

    always_comb begin
        raw = data_buf_valid ? data_buf : lsu.data_sram_rdata;
        sh  = 16'(raw >> {bus_r.addr_lo, 3'b000});
        case (bus_r.ld_size)
            SZ_BYTE: load_data = {{24{bus_r.ld_signed & sh[7]}}, sh[7:0]};
            SZ_HALF: load_data = {{16{bus_r.ld_signed & sh[15]}}, sh};
            default: load_data = raw;
        endcase
    end

    assign final_result = (bus_r.mem_req & bus_r.gr_we & ~bus_r.ex) ? load_data
                                                                      : bus_r.alu_result;

    assign lsu.ms_to_ws_bus = {bus_r.pass, bus_r.gr_we, bus_r.dest, final_result};
    assign lsu.ms_fwd_bus   = {ms_valid & bus_r.gr_we & ~bus_r.ex,
                               wait_resp & ~ms_ready_go,
                               bus_r.dest,
                               final_result};
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: load-alignment vector table, hand-written
// multi-cycle corner cases, then randomized traffic against a transaction-level model.
module tb_mem_stage_lsu;
    localparam int PASS_W   = 180;
    localparam int ES_BUS_W = PASS_W + 45;
    localparam int WS_BUS_W = PASS_W + 38;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    mem_stage_lsu_if #(.PASS_W(PASS_W)) bus_if ();

    mem_stage_lsu #(.PASS_W(PASS_W)) dut (
        .clk   (clk),
        .reset (reset),
        .lsu   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  addr;
        logic        gr_we;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.es_to_ms_valid    = 1'b0;
        bus_if.es_to_ms_bus      = '0;
        bus_if.ws_allowin        = 1'b1;
        bus_if.wb_flush          = 1'b0;
        bus_if.data_sram_data_ok = 1'b0;
        bus_if.data_sram_rdata   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [ES_BUS_W-1:0] mk_es(
        input logic [PASS_W-1:0] pass, input logic ex, input logic mem_req,
        input logic sgn, input logic [1:0] size, input logic [1:0] addr,
        input logic gr_we, input logic [4:0] dest, input logic [31:0] alu);
        return {pass, ex, mem_req, sgn, size, addr, gr_we, dest, alu};
    endfunction

    // Reference: what WB should receive, from the architectural load rules.
    function automatic logic [31:0] model_result(
        input logic ex, input logic mem_req, input logic sgn, input logic [1:0] size,
        input logic [1:0] addr, input logic gr_we, input logic [31:0] alu,
        input logic [31:0] rdata);
        logic [31:0] v;
        if (!mem_req || !gr_we || ex) return alu;
        v = rdata >> (8 * int'(addr));
        if (size == 2'd0) begin
            v = v & 32'h0000_00FF;
            if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = v & 32'h0000_FFFF;
            if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    function automatic logic [PASS_W-1:0] rand_pass();
        logic [191:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[PASS_W-1:0];
    endfunction

    logic [PASS_W-1:0]   pat;
    logic [WS_BUS_W-1:0] exp_q[$];
    logic [WS_BUS_W-1:0] exp_bus;

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        vecs[0] = '{2'd0, 1'b1, 2'd2, 1'b1, 32'h0, 32'h0080_0000, 32'hFFFF_FF80};
        vecs[1] = '{2'd0, 1'b0, 2'd2, 1'b1, 32'h0, 32'h0080_0000, 32'h0000_0080};
        vecs[2] = '{2'd1, 1'b1, 2'd2, 1'b1, 32'h0, 32'h8001_1234, 32'hFFFF_8001};
        vecs[3] = '{2'd1, 1'b0, 2'd0, 1'b1, 32'h0, 32'h1234_F00D, 32'h0000_F00D};
        vecs[4] = '{2'd2, 1'b1, 2'd0, 1'b1, 32'h0, 32'hCAFE_BABE, 32'hCAFE_BABE};
        vecs[5] = '{2'd3, 1'b1, 2'd1, 1'b1, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[6] = '{2'd0, 1'b1, 2'd3, 1'b1, 32'h0, 32'h7F00_0000, 32'h0000_007F};
        vecs[7] = '{2'd1, 1'b1, 2'd0, 1'b1, 32'h0, 32'h0000_7FFF, 32'h0000_7FFF};
        vecs[8] = '{2'd0, 1'b1, 2'd1, 1'b1, 32'h0, 32'h0000_FF00, 32'hFFFF_FFFF};
        vecs[9] = '{2'd2, 1'b0, 2'd0, 1'b0, 32'h1111_2222, 32'h0000_ABCD, 32'h1111_2222};

        do_reset();
        #2;
        check("reset_allowin", bus_if.ms_allowin, 1'b1);
        check("reset_ws_valid", bus_if.ms_to_ws_valid, 1'b0);
        check("reset_ws_bus", bus_if.ms_to_ws_bus, '0);
        check("reset_fwd_bus", bus_if.ms_fwd_bus, '0);
        check("reset_ms_ex", bus_if.ms_ex, 1'b0);

        // ALU op: one cycle in MEM
        bus_if.es_to_ms_valid = 1'b1;
        bus_if.es_to_ms_bus = mk_es('0, 0, 0, 0, 2'd0, 2'd0, 1, 5'd5, 32'h1234_5678);
        cyc();
        bus_if.es_to_ms_valid = 1'b0;
        #2;
        check("alu_valid", bus_if.ms_to_ws_valid, 1'b1);
        check("alu_result", bus_if.ms_to_ws_bus[31:0], 32'h1234_5678);
        check("alu_fwd", bus_if.ms_fwd_bus, {1'b1, 1'b0, 5'd5, 32'h1234_5678});

        // Load alignment table: data_ok in the first cycle the load sits in MEM
        for (int i = 0; i < 10; i++) begin
            cyc();
            bus_if.es_to_ms_valid = 1'b1;
            bus_if.es_to_ms_bus = mk_es('0, 0, 1, vecs[i].sgn, vecs[i].size, vecs[i].addr,
                                        vecs[i].gr_we, 5'd8, vecs[i].alu);
            cyc();
            bus_if.es_to_ms_valid    = 1'b0;
            bus_if.data_sram_data_ok = 1'b1;
            bus_if.data_sram_rdata   = vecs[i].rdata;
            #2;
            check($sformatf("vec%0d_valid", i), bus_if.ms_to_ws_valid, 1'b1);
            check($sformatf("vec%0d_result", i), bus_if.ms_to_ws_bus[31:0], vecs[i].exp);
            cyc();
            bus_if.data_sram_data_ok = 1'b0;
        end

        // Byte load waiting three cycles for data_ok, signed then unsigned
        for (int s = 0; s < 2; s++) begin
            bus_if.es_to_ms_valid = 1'b1;
            bus_if.es_to_ms_bus = mk_es('0, 0, 1, (s == 0), 2'd0, 2'd2, 1, 5'd7, 32'h0);
            cyc();
            bus_if.es_to_ms_valid = 1'b0;
            for (int k = 0; k < 3; k++) begin
                #2;
                check($sformatf("wait%0d_%0d_load_wait", s, k), bus_if.ms_fwd_bus[37], 1'b1);
                check($sformatf("wait%0d_%0d_allowin", s, k), bus_if.ms_allowin, 1'b0);
                check($sformatf("wait%0d_%0d_ws_valid", s, k), bus_if.ms_to_ws_valid, 1'b0);
                cyc();
            end
            bus_if.data_sram_data_ok = 1'b1;
            bus_if.data_sram_rdata   = 32'h0080_0000;
            #2;
            check($sformatf("wait%0d_valid", s), bus_if.ms_to_ws_valid, 1'b1);
            check($sformatf("wait%0d_result", s), bus_if.ms_to_ws_bus[31:0],
                  (s == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
            cyc();
            bus_if.data_sram_data_ok = 1'b0;
        end

        // Back-pressure: response buffered while WB stalls, raw rdata then garbage
        bus_if.es_to_ms_valid = 1'b1;
        bus_if.es_to_ms_bus = mk_es('0, 0, 1, 0, 2'd2, 2'd0, 1, 5'd9, 32'h0);
        cyc();
        bus_if.es_to_ms_valid    = 1'b0;
        bus_if.ws_allowin        = 1'b0;
        bus_if.data_sram_data_ok = 1'b1;
        bus_if.data_sram_rdata   = 32'hCAFE_BABE;
        cyc();
        bus_if.data_sram_data_ok = 1'b0;
        bus_if.data_sram_rdata   = 32'h0;
        for (int k = 0; k < 2; k++) begin
            #2;
            check("bp_buf_valid", dut.data_buf_valid, 1'b1);
            check("bp_ws_valid", bus_if.ms_to_ws_valid, 1'b1);
            check("bp_result_held", bus_if.ms_to_ws_bus[31:0], 32'hCAFE_BABE);
            check("bp_allowin", bus_if.ms_allowin, 1'b0);
            cyc();
        end
        bus_if.ws_allowin = 1'b1;
        #2;
        check("bp_release_result", bus_if.ms_to_ws_bus[31:0], 32'hCAFE_BABE);
        check("bp_release_allowin", bus_if.ms_allowin, 1'b1);
        cyc();
        #2;
        check("bp_buf_cleared", dut.data_buf_valid, 1'b0);
        check("bp_drained", bus_if.ms_to_ws_valid, 1'b0);

        // Flush mid-load with a second load in flight from EXE
        cyc();
        bus_if.es_to_ms_valid = 1'b1;
        bus_if.es_to_ms_bus = mk_es('0, 0, 1, 0, 2'd2, 2'd0, 1, 5'd3, 32'h0);
        cyc();
        bus_if.es_to_ms_bus = mk_es('0, 0, 1, 0, 2'd2, 2'd0, 1, 5'd10, 32'h0);
        bus_if.wb_flush = 1'b1;
        #2;
        check("flush_ws_valid", bus_if.ms_to_ws_valid, 1'b0);
        check("flush_ms_ex", bus_if.ms_ex, 1'b1);
        cyc();
        bus_if.wb_flush = 1'b0;
        bus_if.es_to_ms_bus = mk_es('0, 0, 1, 0, 2'd2, 2'd0, 1, 5'd4, 32'h0);
        #2;
        check("flush_discard_cnt", dut.discard_cnt, 2'd2);
        cyc();
        bus_if.es_to_ms_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus_if.data_sram_data_ok = 1'b1;
            bus_if.data_sram_rdata   = 32'h1111_1111 * (k + 1);
            #2;
            check($sformatf("flush_drop%0d_valid", k), bus_if.ms_to_ws_valid, 1'b0);
            check($sformatf("flush_drop%0d_wait", k), bus_if.ms_fwd_bus[37], 1'b1);
            cyc();
        end
        bus_if.data_sram_rdata = 32'h0000_1234;
        #2;
        check("flush_new_valid", bus_if.ms_to_ws_valid, 1'b1);
        check("flush_new_result", bus_if.ms_to_ws_bus[31:0], 32'h0000_1234);
        check("flush_new_dest", bus_if.ms_to_ws_bus[36:32], 5'd4);
        cyc();
        bus_if.data_sram_data_ok = 1'b0;

        // Exception passthrough: no wait, pass field untouched
        pat = rand_pass();
        bus_if.es_to_ms_valid = 1'b1;
        bus_if.es_to_ms_bus = mk_es(pat, 1, 1, 0, 2'd2, 2'd0, 1, 5'd6, 32'hDEAD_0001);
        cyc();
        bus_if.es_to_ms_valid = 1'b0;
        #2;
        check("ex_valid", bus_if.ms_to_ws_valid, 1'b1);
        check("ex_ms_ex", bus_if.ms_ex, 1'b1);
        check("ex_fwd_we", bus_if.ms_fwd_bus[38], 1'b0);
        check("ex_load_wait", bus_if.ms_fwd_bus[37], 1'b0);
        check("ex_pass", bus_if.ms_to_ws_bus[WS_BUS_W-1:38], pat);
        check("ex_result", bus_if.ms_to_ws_bus[31:0], 32'hDEAD_0001);

        // Asynchronous reset while waiting with stale responses pending
        cyc();
        bus_if.es_to_ms_valid = 1'b1;
        bus_if.es_to_ms_bus = mk_es('0, 0, 1, 0, 2'd2, 2'd0, 1, 5'd1, 32'h0);
        cyc();
        bus_if.wb_flush = 1'b1;
        cyc();
        bus_if.wb_flush = 1'b0;
        cyc();
        bus_if.es_to_ms_valid = 1'b0;
        #2;
        check("arst_pre_allowin", bus_if.ms_allowin, 1'b0);
        reset = 1'b1;
        #1;
        check("arst_allowin", bus_if.ms_allowin, 1'b1);
        check("arst_ms_valid", dut.ms_valid, 1'b0);
        check("arst_discard_cnt", dut.discard_cnt, 2'd0);
        check("arst_fwd_bus", bus_if.ms_fwd_bus, '0);
        cyc();
        reset = 1'b0;

        // Randomized traffic against the transaction-level model
        begin
            logic              offer_active;
            logic              pending;
            logic [31:0]       pend_rdata;
            logic [PASS_W-1:0] o_pass;
            logic              o_ex, o_mem, o_sgn, o_we;
            logic [1:0]        o_size, o_addr;
            logic [4:0]        o_dest;
            logic [31:0]       o_alu, o_rdata;

            do_reset();
            offer_active = 1'b0;
            pending      = 1'b0;
            pend_rdata   = '0;
            for (int c = 0; c < 3000 + 40; c++) begin
                if (c != 0) cyc();
                if (c < 3000 && !offer_active && $urandom_range(0, 99) < 60) begin
                    o_pass  = rand_pass();
                    o_ex    = ($urandom_range(0, 9) == 0);
                    o_mem   = 1'($urandom_range(0, 1));
                    o_sgn   = 1'($urandom_range(0, 1));
                    o_size  = 2'($urandom_range(0, 3));
                    o_addr  = 2'($urandom_range(0, 3));
                    o_we    = 1'($urandom_range(0, 1));
                    o_dest  = 5'($urandom_range(0, 31));
                    o_alu   = $urandom();
                    o_rdata = $urandom();
                    offer_active = 1'b1;
                    bus_if.es_to_ms_bus = mk_es(o_pass, o_ex, o_mem, o_sgn, o_size, o_addr,
                                                o_we, o_dest, o_alu);
                end
                bus_if.es_to_ms_valid    = offer_active;
                bus_if.ws_allowin        = (c >= 3000) || ($urandom_range(0, 99) < 70);
                bus_if.data_sram_data_ok = pending && ((c >= 3000) || ($urandom_range(0, 99) < 40));
                bus_if.data_sram_rdata   = bus_if.data_sram_data_ok ? pend_rdata : $urandom();
                #2;
                if (bus_if.ms_to_ws_valid && bus_if.ws_allowin) begin
                    if (exp_q.size() == 0) begin
                        check("rand_unexpected_output", bus_if.ms_to_ws_valid, 1'b0);
                    end else begin
                        exp_bus = exp_q.pop_front();
                        check($sformatf("rand_out_c%0d", c), bus_if.ms_to_ws_bus, exp_bus);
                    end
                end
                if (bus_if.data_sram_data_ok) pending = 1'b0;
                if (offer_active && bus_if.ms_allowin) begin
                    exp_q.push_back({o_pass, o_we, o_dest,
                                     model_result(o_ex, o_mem, o_sgn, o_size, o_addr, o_we,
                                                  o_alu, o_rdata)});
                    if (o_mem && !o_ex) begin
                        pending    = 1'b1;
                        pend_rdata = o_rdata;
                    end
                    offer_active = 1'b0;
                end
            end
            check("rand_drained", 32'(exp_q.size()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
